// File: rtl/tiled_dot_pkg.sv
// Shared helpers for the tiled dot-product engine: log2 sizing, pipeline latency, control states.
package tiled_dot_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  localparam int DEF_NUM_MULT = 16;
  localparam int LAT = clog2(DEF_NUM_MULT) + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

endpackage

// File: rtl/dot_lane_tree.sv
// One core: NUM_MULT lane multipliers against the stationary vector, then a registered adder tree.
// Node layout is level-major: level l occupies [2N - 2N>>l, +N>>l), the root is the last node.
module dot_lane_tree
  import tiled_dot_pkg::*;
#(
  parameter int NUM_MULT  = 16,
  parameter int WORD_SIZE = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       stall,
  input  logic                                       sgn,
  input  logic [NUM_MULT*WORD_SIZE-1:0]              stat,
  input  logic [NUM_MULT*WORD_SIZE-1:0]              vec,
  output logic [2*WORD_SIZE+clog2(NUM_MULT)-1:0]     sum
);

  localparam int LG    = clog2(NUM_MULT);
  localparam int W     = WORD_SIZE;
  localparam int SUMW  = 2*W + LG;
  localparam int NODES = 2*NUM_MULT - 1;

  function automatic int off(input int l);
    return 2*NUM_MULT - ((2*NUM_MULT) >> l);
  endfunction

  // Products are extended to the full tree width up front so every level adds like-signed values.
  function automatic logic [SUMW-1:0] mul_ext(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    logic [2*W-1:0] p;
    if (s) p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    else   p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return s ? {{LG{p[2*W-1]}}, p} : {{LG{1'b0}}, p};
  endfunction

  logic [SUMW-1:0] node [NODES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) node[i] <= '0;
    end else if (!stall) begin
      for (int i = 0; i < NUM_MULT; i++)
        node[i] <= mul_ext(stat[i*W +: W], vec[i*W +: W], sgn);
      for (int l = 1; l <= LG; l++)
        for (int j = 0; j < (NUM_MULT >> l); j++)
          node[off(l)+j] <= node[off(l-1)+2*j] + node[off(l-1)+2*j+1];
    end
  end

  assign sum = node[NODES-1];

endmodule

// File: rtl/tiled_dot_engine.sv
// Multi-core dot-product engine: one stationary vector against NUM_CORES streams, accumulated per group.
// Result appears clog2(NUM_MULT)+2 cycles after a group's last beat; a held result stalls the whole pipe.
module tiled_dot_engine
  import tiled_dot_pkg::*;
#(
  parameter int NUM_MULT   = 16,
  parameter int NUM_CORES  = 4,
  parameter int WORD_SIZE  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int TILE_CNT_W = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cfg_signed,
  input  logic [TILE_CNT_W-1:0]                     cfg_tiles,
  input  logic                                      ld_valid,
  output logic                                      ld_ready,
  input  logic [NUM_MULT*WORD_SIZE-1:0]             ld_data,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [NUM_CORES*NUM_MULT*WORD_SIZE-1:0]   in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [NUM_CORES*ACC_WIDTH-1:0]            out_data,
  output logic                                      busy
);

  localparam int LG   = clog2(NUM_MULT);
  localparam int VW   = NUM_MULT*WORD_SIZE;
  localparam int SUMW = 2*WORD_SIZE + LG;
  localparam int EXTW = ACC_WIDTH - SUMW;

  state_t                    state, state_nx;
  logic [VW-1:0]             stat;
  logic [TILE_CNT_W-1:0]     cnt, tiles_q, beat_tiles;
  logic                      sgn_q, beat_sgn, beat_first, beat_last;
  logic                      stall, ld_take, in_take, pipe_empty;
  logic [LG:0]               t_vld, t_first, t_last, t_sgn;
  logic [NUM_CORES*SUMW-1:0] sums;
  logic [ACC_WIDTH-1:0]      acc    [NUM_CORES];
  logic [ACC_WIDTH-1:0]      acc_nx [NUM_CORES];

  assign stall      = out_valid & ~out_ready;
  assign pipe_empty = ~|t_vld;

  always_comb begin
    ld_ready   = (state == IDLE) & pipe_empty & ~stall;
    ld_take    = ld_valid & ld_ready;
    in_ready   = ~stall & ~ld_take;
    in_take    = in_valid & in_ready;
    beat_first = (cnt == '0);
    beat_tiles = tiles_q;
    beat_sgn   = sgn_q;
    if (beat_first) begin
      beat_tiles = (cfg_tiles == '0) ? TILE_CNT_W'(1) : cfg_tiles;
      beat_sgn   = cfg_signed;
    end
    beat_last = ((cnt + TILE_CNT_W'(1)) == beat_tiles);
    busy      = (state != IDLE) | ~pipe_empty | out_valid;
    state_nx  = state;
    case (state)
      IDLE:    if (in_take) state_nx = beat_last ? DRAIN : ACCUM;
      ACCUM:   if (in_take && beat_last) state_nx = DRAIN;
      DRAIN: begin
        if (in_take)                       state_nx = beat_last ? DRAIN : ACCUM;
        else if (pipe_empty && !out_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Group config is latched on the first beat; tags travel alongside the tree levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat    <= '0;
      cnt     <= '0;
      tiles_q <= '0;
      sgn_q   <= 1'b0;
      t_vld   <= '0;
      t_first <= '0;
      t_last  <= '0;
      t_sgn   <= '0;
    end else begin
      if (ld_take) stat <= ld_data;
      if (in_take) begin
        cnt <= beat_last ? '0 : cnt + TILE_CNT_W'(1);
        if (beat_first) begin
          tiles_q <= beat_tiles;
          sgn_q   <= beat_sgn;
        end
      end
      if (!stall) begin
        t_vld   <= {t_vld[LG-1:0],   in_take};
        t_first <= {t_first[LG-1:0], beat_first};
        t_last  <= {t_last[LG-1:0],  beat_last};
        t_sgn   <= {t_sgn[LG-1:0],   beat_sgn};
      end
    end
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    dot_lane_tree #(
      .NUM_MULT  (NUM_MULT),
      .WORD_SIZE (WORD_SIZE)
    ) u_tree (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .sgn   (beat_sgn),
      .stat  (stat),
      .vec   (in_data[c*VW +: VW]),
      .sum   (sums[c*SUMW +: SUMW])
    );
  end

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      acc_nx[c] = (t_first[LG] ? '0 : acc[c]) +
                  (t_sgn[LG] ? {{EXTW{sums[c*SUMW+SUMW-1]}}, sums[c*SUMW +: SUMW]}
                             : {{EXTW{1'b0}}, sums[c*SUMW +: SUMW]});
    end
  end

  // When not stalled, any previous result is either absent or consumed this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CORES; c++) acc[c] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= t_vld[LG] & t_last[LG];
      if (t_vld[LG]) begin
        for (int c = 0; c < NUM_CORES; c++) begin
          acc[c] <= acc_nx[c];
          if (t_last[LG]) out_data[c*ACC_WIDTH +: ACC_WIDTH] <= acc_nx[c];
        end
      end
    end
  end

endmodule
